// File: rtl/uart_tx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - parity mode encodings for the 2-bit par field
//   - transmitter FSM state type
//   - minimum legal frame length and the idle level of the serial line
//   - clampDlen(): forces a requested data length into MIN_DLEN..maxLen
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int MIN_DLEN   = 5;
  localparam int IDLE_LEVEL = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_e;

  // Out-of-range lengths are pulled to the nearest legal value instead of
  // being rejected, so a bad register write still produces a sane frame.
  function automatic logic [4:0] clampDlen(input logic [4:0] d, input int maxLen);
    if (int'(d) < MIN_DLEN) begin
      return 5'(MIN_DLEN);
    end else if (int'(d) > maxLen) begin
      return 5'(maxLen);
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Write / configuration / status bundle of the buffered UART transmitter.
//   master : the sampling logic feeding words (drives wr_en, wr_data, config)
//   slave  : the transmitter (drives dout and the FIFO / frame status)
// Signals:
//   wr_en, wr_data          push a word into the transmit FIFO
//   baud_div                bit period = baud_div+1 clk cycles
//   dlen, par, snum         frame format, latched per word at pop time
//   dout                    serial line, idles high
//   busy, tx_done           frame in progress / end-of-frame pulse
//   full, empty, level      FIFO status
//   overflow                sticky, a write arrived while full
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DIV_W-1:0]  baud_div;
  logic [4:0]        dlen;
  logic [1:0]        par;
  logic              snum;
  logic              dout;
  logic              busy;
  logic              tx_done;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  modport master (
    output wr_en, wr_data, baud_div, dlen, par, snum,
    input  dout, busy, tx_done, full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data, baud_div, dlen, par, snum,
    output dout, busy, tx_done, full, empty, level, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty/level flags.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data (ignored while full)
//   pop_i             read request (ignored while empty)
//   rdata_o           head of the FIFO, valid whenever !empty_o
//   full_o, empty_o   registered flags
//   level_o           registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, empty_q;
  logic             doPush, doPop;

  // A write while full is dropped even if a read frees a slot in the same
  // cycle, so push qualification looks only at the registered full flag.
  assign doPush = push_i && !full_q;
  assign doPop  = pop_i && !empty_q;

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + LVL_W'(1);
    end else if (doPop && !doPush) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pointers and flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage needs no reset: the pointers decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Words pushed through the interface wait in a
// FIFO and are sent LSB-first as: start bit, dlen data bits, optional parity
// bit, one or two stop bits. Bit period is baud_div+1 clk cycles.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset; aborts any frame, empties FIFO
//   bus     uart_tx_fifo_if slave modport (write, config, line, status)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input logic            clk_i,
  input logic            rst_ni,
  uart_tx_fifo_if.slave  bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] fifoRdata;
  logic              fifoFull, fifoEmpty;
  logic [LVL_W-1:0]  fifoLevel;
  logic              pop;

  txState_e          state_q, state_d;
  logic [DIV_W-1:0]  baudCnt_q, baudCnt_d;
  logic [4:0]        bitIdx_q, bitIdx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [4:0]        dlen_q, dlen_d;
  logic [1:0]        par_q, par_d;
  logic              snum_q, snum_d;
  logic              parBit_q, parBit_d;
  logic              txDone_q, txDone_d;
  logic              overflow_q, overflow_d;

  logic              bitEnd;
  logic [4:0]        dlenClamped;
  logic [DATA_W-1:0] dataMask;
  logic [DATA_W-1:0] maskedWord;
  logic              dataXor;
  logic              doutComb;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.wr_en),
    .pop_i   (pop),
    .wdata_i (bus.wr_data),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // Word masking and parity of the head word, evaluated on the pop cycle so
  // the parity bit is ready before the frame even starts.
  assign dlenClamped = clampDlen(bus.dlen, DATA_W);

  always_comb begin
    dataMask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dataMask[i] = (i < int'(dlenClamped));
    end
  end

  assign maskedWord = fifoRdata & dataMask;
  assign dataXor    = ^maskedWord;
  assign bitEnd     = (state_q != IDLE) && (baudCnt_q == bus.baud_div);

  // Baud counter: parked at zero while idle, otherwise wraps at baud_div.
  always_comb begin
    baudCnt_d = '0;
    if (state_q != IDLE && !bitEnd) begin
      baudCnt_d = baudCnt_q + DIV_W'(1);
    end
  end

  // Frame sequencing. The last stop bit either returns to IDLE or, when more
  // data is queued, pops immediately so frames run back-to-back without an
  // idle bit in between. bitIdx_q counts data bits in DATA and stop bits in
  // STOP.
  always_comb begin
    state_d    = state_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    dlen_d     = dlen_q;
    par_d      = par_q;
    snum_d     = snum_q;
    parBit_d   = parBit_q;
    txDone_d   = 1'b0;
    pop        = 1'b0;
    overflow_d = overflow_q | (bus.wr_en & fifoFull);

    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = shift_q >> 1;
          if (bitIdx_q == dlen_q - 5'd1) begin
            bitIdx_d = '0;
            state_d  = (par_q != PAR_NONE) ? PARITY : STOP;
          end else begin
            bitIdx_d = bitIdx_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d  = STOP;
          bitIdx_d = '0;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (bitIdx_q == {4'b0, snum_q}) begin
            txDone_d = 1'b1;
            if (!fifoEmpty) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitIdx_d = bitIdx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Format is captured together with the word so mid-frame config changes
    // only affect the following frame.
    if (pop) begin
      shift_d = maskedWord;
      dlen_d  = dlenClamped;
      par_d   = bus.par;
      snum_d  = bus.snum;
      case (bus.par)
        PAR_EVEN: parBit_d = dataXor;
        PAR_ODD:  parBit_d = ~dataXor;
        PAR_MARK: parBit_d = 1'b1;
        default:  parBit_d = 1'b1;
      endcase
    end
  end

  // State register for the transmitter and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      dlen_q     <= 5'(DATA_W);
      par_q      <= PAR_NONE;
      snum_q     <= 1'b0;
      parBit_q   <= 1'b0;
      txDone_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      dlen_q     <= dlen_d;
      par_q      <= par_d;
      snum_q     <= snum_d;
      parBit_q   <= parBit_d;
      txDone_q   <= txDone_d;
      overflow_q <= overflow_d;
    end
  end

  // Line level is decoded straight from the state so a reset forces the
  // line high without waiting for a clock edge.
  always_comb begin
    doutComb = 1'(IDLE_LEVEL);
    case (state_q)
      START:   doutComb = 1'b0;
      DATA:    doutComb = shift_q[0];
      PARITY:  doutComb = parBit_q;
      default: doutComb = 1'(IDLE_LEVEL);
    endcase
  end

  assign bus.dout     = doutComb;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_done  = txDone_q;
  assign bus.full     = fifoFull;
  assign bus.empty    = fifoEmpty;
  assign bus.level    = fifoLevel;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. Expected line waveforms are built
// from the frame rules (start, data LSB-first, parity, stops, bit period)
// and compared cycle by cycle with dout, busy and tx_done.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;
  localparam int START_BUDGET = 500;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectorCount = 0;
  int missCount   = 0;

  logic expDout[$];
  logic expBusy[$];
  logic expDone[$];

  always #5 clk = ~clk;

  uart_tx_fifo_if #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) bus ();

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int effDlen(input int d);
    if (d < 5) return 5;
    if (d > DATA_W) return DATA_W;
    return d;
  endfunction

  // Appends one frame to the expected waveform. A frame that follows another
  // one directly begins in the cycle where the previous tx_done pulse shows.
  function automatic void addFrame(input logic [15:0] word, input int dlen,
                                   input logic [1:0] parMode, input bit twoStop,
                                   input int div);
    bit bits[$];
    int n     = effDlen(dlen);
    int ones  = 0;
    int first = expDout.size();
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (parMode == 2'd1) bits.push_back((ones % 2) == 1);
    if (parMode == 2'd2) bits.push_back((ones % 2) == 0);
    if (parMode == 2'd3) bits.push_back(1'b1);
    bits.push_back(1'b1);
    if (twoStop) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int c = 0; c <= div; c++) begin
        expDout.push_back(bits[b]);
        expBusy.push_back(1'b1);
        expDone.push_back(1'b0);
      end
    end
    if (first > 0) expDone[first] = 1'b1;
  endfunction

  function automatic void finishStream();
    expDout.push_back(1'b1);
    expBusy.push_back(1'b0);
    expDone.push_back(1'b1);
  endfunction

  function automatic void clearStream();
    expDout.delete();
    expBusy.delete();
    expDone.delete();
  endfunction

  // Waits (bounded) for the start bit, then walks the expected waveform.
  task automatic checkStream(output int waited);
    waited = 0;
    while (bus.dout !== 1'b0 && waited < START_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= START_BUDGET) begin
      checkOutput("startTimeout", 32'(waited), 32'd0);
      return;
    end
    foreach (expDout[i]) begin
      checkOutput($sformatf("dout@%0d", i), 32'(bus.dout), 32'(expDout[i]));
      checkOutput($sformatf("busy@%0d", i), 32'(bus.busy), 32'(expBusy[i]));
      checkOutput($sformatf("txDone@%0d", i), 32'(bus.tx_done), 32'(expDone[i]));
      @(negedge clk);
    end
  endtask

  // One-cycle write; consecutive calls produce back-to-back writes.
  task automatic applyStimulus(input logic [15:0] word);
    bus.wr_data = word[DATA_W-1:0];
    bus.wr_en   = 1'b1;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic setConfig(input int div, input int dl, input logic [1:0] p,
                           input bit s);
    bus.baud_div = DIV_W'(div);
    bus.dlen     = 5'(dl);
    bus.par      = p;
    bus.snum     = s;
  endtask

  task automatic singleFrame(input logic [15:0] word, input int div, input int dl,
                             input logic [1:0] p, input bit s);
    int w;
    setConfig(div, dl, p, s);
    clearStream();
    addFrame(word, dl, p, s, div);
    finishStream();
    fork
      applyStimulus(word);
      checkStream(w);
    join
    checkOutput("latency", 32'(w), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    logic [15:0] words[10];
    logic [15:0] w0, w1;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    setConfig(3, 8, PAR_NONE, 1'b0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstDout", 32'(bus.dout), 32'd1);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstTxDone", 32'(bus.tx_done), 32'd0);
    checkOutput("rstEmpty", 32'(bus.empty), 32'd1);
    checkOutput("rstFull", 32'(bus.full), 32'd0);
    checkOutput("rstLevel", 32'(bus.level), 32'd0);
    checkOutput("rstOverflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, 8N1, 4-cycle bits
    singleFrame(16'h00A5, 3, 8, PAR_NONE, 1'b0);
    repeat (3) @(negedge clk);

    // Parity modes on a 7-bit frame; bit 7 set to confirm it is masked off
    singleFrame(16'h0087, 1, 7, PAR_EVEN, 1'b0);
    singleFrame(16'h0087, 1, 7, PAR_ODD, 1'b0);
    singleFrame(16'h0087, 1, 7, PAR_MARK, 1'b0);

    // Two stop bits, short frame, clamped lengths
    singleFrame(16'h001F, 2, 5, PAR_NONE, 1'b1);
    singleFrame(16'($urandom), 1, 3, PAR_NONE, 1'b0);
    singleFrame(16'($urandom), 0, 20, PAR_EVEN, 1'b1);

    // Mid-frame dlen change only affects the next frame
    w0 = 16'($urandom);
    w1 = 16'($urandom);
    setConfig(2, 8, PAR_NONE, 1'b0);
    clearStream();
    addFrame(w0, 8, PAR_NONE, 1'b0, 2);
    addFrame(w1, 6, PAR_NONE, 1'b0, 2);
    finishStream();
    fork
      begin
        applyStimulus(w0);
        applyStimulus(w1);
        repeat (8) @(negedge clk);
        bus.dlen = 5'd6;
      end
      checkStream(waited);
    join

    // Random single frames
    for (int k = 0; k < 6; k++) begin
      singleFrame(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Burst of 10 writes: the first word leaves for the shift register the
    // cycle after it lands, so 9 are accepted and the 10th overflows.
    checkOutput("ovfBeforeBurst", 32'(bus.overflow), 32'd0);
    setConfig(1, 8, PAR_NONE, 1'b0);
    foreach (words[i]) words[i] = 16'($urandom);
    clearStream();
    for (int i = 0; i < 9; i++) addFrame(words[i], 8, PAR_NONE, 1'b0, 1);
    finishStream();
    fork
      begin
        for (int i = 0; i < 10; i++) applyStimulus(words[i]);
        checkOutput("burstLevel", 32'(bus.level), 32'd8);
        checkOutput("burstFull", 32'(bus.full), 32'd1);
        checkOutput("burstEmpty", 32'(bus.empty), 32'd0);
        checkOutput("burstOverflow", 32'(bus.overflow), 32'd1);
      end
      checkStream(waited);
    join
    checkOutput("ovfSticky", 32'(bus.overflow), 32'd1);
    checkOutput("drainEmpty", 32'(bus.empty), 32'd1);

    // Reset in the middle of DATA with a second word still queued
    setConfig(3, 8, PAR_NONE, 1'b0);
    applyStimulus(16'($urandom));
    applyStimulus(16'($urandom));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstDout", 32'(bus.dout), 32'd1);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstEmpty", 32'(bus.empty), 32'd1);
    checkOutput("midRstLevel", 32'(bus.level), 32'd0);
    checkOutput("midRstOverflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checkOutput($sformatf("quietDout@%0d", i), 32'(bus.dout), 32'd1);
      checkOutput($sformatf("quietBusy@%0d", i), 32'(bus.busy), 32'd0);
    end
    singleFrame(16'h005A, 0, 8, PAR_ODD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
